// File: rtl/matrix_framebuf.sv
// Double-buffered 8x8 frame store feeding the LED matrix scan driver; swaps happen only on a frame boundary.
// Define FB_READBACK_EN to build the register read path; without it DOUT is tied to 8'h00 and RE is ignored.
module matrix_framebuf #(
  parameter logic [63:0] INIT_PATTERN = 64'h0,
  parameter logic        OE_RESET     = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  ADDR,
  input  logic [7:0]  DIN,
  input  logic        WE,
  input  logic        RE,
  output logic [7:0]  DOUT,
  output logic [63:0] DATA,
  output logic        OE,
  output logic        PEND
);

  logic [63:0] front_r;
  logic [63:0] back_r;
  logic [63:0] back_next_s;
  logic        oe_r;
  logic        pend_r;
  logic        clr_r;
  logic [2:0]  phase_r;
  logic        swap_s;
  logic        ctrl_wr_s;
  logic        row_wr_s;
  logic        pend_next_s;
  logic        clr_next_s;
  logic        oe_next_s;
  logic [2:0]  phase_next_s;
  logic [63:0] front_next_s;

  // Swap decision and next-state for the buffers and control bits.
  always_comb begin
    swap_s       = pend_r && ((phase_r == 3'd7) || !oe_r);
    ctrl_wr_s    = WE && (ADDR == 4'd8);
    row_wr_s     = WE && !ADDR[3];
    back_next_s  = back_r;
    front_next_s = swap_s ? back_r : front_r;
    // A row written on the swap edge keeps DIN even when the clear is armed.
    for (int r = 0; r < 8; r++) begin
      if (row_wr_s && (ADDR[2:0] == 3'(r))) begin
        back_next_s[8*r +: 8] = DIN;
      end else if (swap_s && clr_r) begin
        back_next_s[8*r +: 8] = 8'h00;
      end else begin
        back_next_s[8*r +: 8] = back_r[8*r +: 8];
      end
    end
    // A new swap request beats the clear of the one being serviced.
    if (ctrl_wr_s && DIN[1]) begin
      pend_next_s = 1'b1;
    end else if (swap_s) begin
      pend_next_s = 1'b0;
    end else begin
      pend_next_s = pend_r;
    end
    if (ctrl_wr_s) begin
      clr_next_s = DIN[2];
    end else if (swap_s) begin
      clr_next_s = 1'b0;
    end else begin
      clr_next_s = clr_r;
    end
    oe_next_s    = ctrl_wr_s ? DIN[0] : oe_r;
    phase_next_s = oe_r ? (phase_r + 3'd1) : 3'd0;
  end

  // Frame buffers, control bits and the row-phase mirror of the driver.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      front_r <= INIT_PATTERN;
      back_r  <= INIT_PATTERN;
      oe_r    <= OE_RESET;
      pend_r  <= 1'b0;
      clr_r   <= 1'b0;
      phase_r <= 3'd0;
    end else begin
      front_r <= front_next_s;
      back_r  <= back_next_s;
      oe_r    <= oe_next_s;
      pend_r  <= pend_next_s;
      clr_r   <= clr_next_s;
      phase_r <= phase_next_s;
    end
  end

  assign DATA = front_r;
  assign OE   = oe_r;
  assign PEND = pend_r;

`ifdef FB_READBACK_EN
  logic [7:0] rd_data_s;
  logic [7:0] dout_r;

  // Register read mux; sees pre-write state so a same-cycle write is not reflected.
  always_comb begin
    rd_data_s = 8'h00;
    if (!ADDR[3]) begin
      rd_data_s = back_r[{ADDR[2:0], 3'b000} +: 8];
    end else begin
      case (ADDR[2:0])
        3'd0:    rd_data_s = {5'b00000, clr_r, pend_r, oe_r};
        3'd1:    rd_data_s = {1'b0, phase_r, 3'b000, pend_r};
        default: rd_data_s = 8'h00;
      endcase
    end
  end

  // Read data register, held between reads.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout_r <= 8'h00;
    end else if (RE) begin
      dout_r <= rd_data_s;
    end else begin
      dout_r <= dout_r;
    end
  end

  assign DOUT = dout_r;
`else
  logic unused_re_s;
  assign unused_re_s = RE;
  assign DOUT        = 8'h00;
`endif

endmodule

// File: tb/tb_matrix_framebuf.sv
// Scoreboard bench for matrix_framebuf: a byte-array reference model predicts every cycle,
// a monitor process pops and compares DATA/OE/PEND/DOUT one cycle after each stimulus.
module tb_matrix_framebuf;

  localparam logic [63:0] INIT = 64'h0123456789ABCDEF;
`ifdef FB_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  ADDR;
  logic [7:0]  DIN;
  logic        WE;
  logic        RE;
  logic [7:0]  DOUT;
  logic [63:0] DATA;
  logic        OE;
  logic        PEND;

  matrix_framebuf #(.INIT_PATTERN(INIT), .OE_RESET(1'b0)) dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .DIN(DIN), .WE(WE), .RE(RE),
    .DOUT(DOUT), .DATA(DATA), .OE(OE), .PEND(PEND)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [63:0] data;
    logic        oe;
    logic        pend;
    logic [7:0]  dout;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;

  // Reference model: rows as bytes, phase as a plain integer.
  logic [7:0] m_front[8];
  logic [7:0] m_back[8];
  logic       m_oe, m_pend, m_clr;
  int         m_phase;
  logic [7:0] m_dout;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] front_word();
    logic [63:0] v;
    for (int r = 0; r < 8; r++) v[8*r +: 8] = m_front[r];
    return v;
  endfunction

  task automatic model_reset();
    logic [63:0] ip;
    ip = INIT;
    for (int r = 0; r < 8; r++) begin
      m_front[r] = ip[8*r +: 8];
      m_back[r]  = ip[8*r +: 8];
    end
    m_oe = 1'b0; m_pend = 1'b0; m_clr = 1'b0; m_phase = 0; m_dout = 8'h00;
  endtask

  // One bus cycle: drive, predict, queue the expectation, return just after the edge.
  task automatic cycle(input logic we, input logic re, input logic [3:0] addr, input logic [7:0] din);
    logic       swap;
    logic [7:0] rv;
    logic [7:0] nb[8];
    exp_t       e;
    @(negedge CLK);
    WE = we; RE = re; ADDR = addr; DIN = din;
    swap = m_pend && (m_phase == 7 || !m_oe);
    if (addr < 4'd8)       rv = m_back[addr[2:0]];
    else if (addr == 4'd8) rv = {5'b00000, m_clr, m_pend, m_oe};
    else if (addr == 4'd9) rv = {1'b0, 3'(m_phase), 3'b000, m_pend};
    else                   rv = 8'h00;
    if (re && RB) m_dout = rv;
    for (int r = 0; r < 8; r++) begin
      nb[r] = (swap && m_clr) ? 8'h00 : m_back[r];
      if (swap) m_front[r] = m_back[r];
    end
    if (we && addr < 4'd8) nb[addr[2:0]] = din;
    for (int r = 0; r < 8; r++) m_back[r] = nb[r];
    m_phase = m_oe ? (m_phase + 1) % 8 : 0;
    if (we && addr == 4'd8 && din[1]) m_pend = 1'b1;
    else if (swap)                    m_pend = 1'b0;
    if (we && addr == 4'd8)           m_clr = din[2];
    else if (swap)                    m_clr = 1'b0;
    if (we && addr == 4'd8)           m_oe = din[0];
    e.data = front_word(); e.oe = m_oe; e.pend = m_pend; e.dout = m_dout;
    q.push_back(e);
    @(posedge CLK);
    #2;
  endtask

  // Monitor: compares the DUT against the oldest queued expectation after each edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("sb_data", DATA, e.data);
        check("sb_oe",   {63'd0, OE}, {63'd0, e.oe});
        check("sb_pend", {63'd0, PEND}, {63'd0, e.pend});
        check("sb_dout", {56'd0, DOUT}, {56'd0, e.dout});
      end
    end
  end

  initial begin : stim
    int guard;
    logic [63:0] ip;
    ip = INIT;
    RST = 1'b1; WE = 1'b0; RE = 1'b0; ADDR = 4'd0; DIN = 8'h00;
    model_reset();
    #12;
    check("rst_data", DATA, INIT);
    check("rst_oe",   {63'd0, OE}, 64'd0);
    check("rst_pend", {63'd0, PEND}, 64'd0);
    check("rst_dout", {56'd0, DOUT}, 64'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Swap with the display off: happens on the very next edge.
    for (int r = 0; r < 8; r++) cycle(1'b1, 1'b0, 4'(r), 8'(1 << r));
    cycle(1'b1, 1'b0, 4'd8, 8'h02);
    check("t2_pend_set", {63'd0, PEND}, 64'd1);
    check("t2_data_old", DATA, INIT);
    cycle(1'b0, 1'b0, 4'd0, 8'h00);
    check("t2_pend_clr", {63'd0, PEND}, 64'd0);
    check("t2_data_new", DATA, 64'h8040201008040201);

    // Swap while scanning: waits for the phase-7 edge.
    cycle(1'b1, 1'b0, 4'd8, 8'h01);
    guard = 0;
    while (m_phase != 3 && guard < 16) begin
      cycle(1'b0, 1'b1, 4'd9, 8'h00);
      guard++;
    end
    cycle(1'b1, 1'b0, 4'd7, 8'hFF);
    cycle(1'b1, 1'b0, 4'd8, 8'h03);
    guard = 0;
    while (m_pend && guard < 16) begin
      check("t3_row7_hold", {56'd0, DATA[63:56]}, 64'h80);
      cycle(1'b0, 1'b1, 4'd9, 8'h00);
      guard++;
    end
    check("t3_pend_clr", {63'd0, PEND}, 64'd0);
    check("t3_row7_new", {56'd0, DATA[63:56]}, 64'hFF);

    // Row write on the swap edge: front gets the old byte.
    cycle(1'b1, 1'b0, 4'd8, 8'h03);
    guard = 0;
    while (!(m_pend && m_phase == 7) && guard < 20) begin
      cycle(1'b0, 1'b0, 4'd0, 8'h00);
      guard++;
    end
    check("t4_setup_pend", {63'd0, PEND}, 64'd1);
    cycle(1'b1, 1'b0, 4'd2, 8'hAA);
    check("t4_row2_old", {56'd0, DATA[23:16]}, 64'h04);
    cycle(1'b0, 1'b1, 4'd2, 8'h00);
    check("t4_back2_read", {56'd0, DOUT}, RB ? 64'hAA : 64'h00);

    // Swap with clear-back armed.
    for (int r = 0; r < 8; r++) cycle(1'b1, 1'b0, 4'(r), 8'h55);
    cycle(1'b1, 1'b0, 4'd8, 8'h07);
    guard = 0;
    while (m_pend && guard < 20) begin
      cycle(1'b0, 1'b0, 4'd0, 8'h00);
      guard++;
    end
    check("t5_pend_clr", {63'd0, PEND}, 64'd0);
    check("t5_data", DATA, 64'h5555555555555555);
    for (int r = 0; r < 8; r++) begin
      cycle(1'b0, 1'b1, 4'(r), 8'h00);
      check("t5_back_zero", {56'd0, DOUT}, 64'h00);
    end

    // Reset mid-frame with a swap pending at phase 5.
    guard = 0;
    while (!(m_pend && m_phase == 5) && guard < 40) begin
      if (!m_pend) cycle(1'b1, 1'b0, 4'd8, 8'h03);
      else         cycle(1'b0, 1'b0, 4'd0, 8'h00);
      guard++;
    end
    check("t6_setup_pend", {63'd0, PEND}, 64'd1);
    @(negedge CLK);
    RST = 1'b1; WE = 1'b0; RE = 1'b0;
    #1;
    check("t6_pend", {63'd0, PEND}, 64'd0);
    check("t6_data", DATA, INIT);
    check("t6_oe",   {63'd0, OE}, 64'd0);
    check("t6_dout", {56'd0, DOUT}, 64'd0);
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    cycle(1'b0, 1'b1, 4'd0, 8'h00);
    check("t6_back0_read", {56'd0, DOUT}, RB ? {56'd0, ip[7:0]} : 64'h00);
    cycle(1'b0, 1'b1, 4'd9, 8'h00);

    // Randomized traffic, CTRL writes biased up so swaps and OE toggles are frequent.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] a;
      a = ($urandom_range(0, 9) < 2) ? 4'd8 : 4'($urandom_range(0, 15));
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 8'($urandom));
    end

    @(negedge CLK);
    WE = 1'b0; RE = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_framebuf.md
Name: matrix_framebuf

Overview:
Double-buffered 8x8 frame store that sits directly upstream of the LED matrix scan driver. The MCS-51 bus side writes row bytes into a back buffer and requests a swap. The front buffer drives the driver's 64-bit DATA and OE inputs. Swaps occur only at a scan-frame boundary, so the driver never displays a torn frame.

Parameters:
INIT_PATTERN, 64'h0, reset value of both the front and back buffers.
OE_RESET, 1'b0, reset value of the display-enable bit (CTRL[0]).

Ports:
CLK    input   1   system clock; all logic on posedge.
RST    input   1   asynchronous, active-high reset.
ADDR   input   4   register address.
DIN    input   8   write data.
WE     input   1   write strobe, one transfer per cycle while high.
RE     input   1   read strobe.
DOUT   output  8   read data, registered.
DATA   output  64  front buffer to the driver; row r = DATA[8r+7:8r].
OE     output  1   display enable to the driver (= CTRL[0]).
PEND   output  1   swap pending flag.

Behaviour:
- Reset (async, RST=1):
  - front = back = INIT_PATTERN
  - OE = OE_RESET
  - PEND = 0, phase = 0, DOUT = 0
  - Reset mid-swap discards the pending request.
- Address map:
  - 0-7 BACK[r]: read/write back-buffer row r.
  - 8 CTRL, write:
    - bit0 = OE enable.
    - bit1 = SWAP request (write-1 sets PEND; writing 0 has no effect).
    - bit2 = CLRBACK: back buffer becomes all-zero at the swap edge, after the copy.
  - 8 CTRL, read: {5'b0, CLRBACK latched, PEND, OE}.
  - 9 STATUS (read-only): {1'b0, phase[2:0], 3'b0, PEND}. Writes are ignored.
  - 10-15: writes ignored, reads return 8'h00.
- Phase counter:
  - 3-bit counter that mirrors the driver's row select.
  - When OE=0, phase is forced to 0.
  - When OE=1, phase increments by 1 every cycle and wraps 7->0.
  - When OE goes 0->1, the first enabled cycle has phase=0, matching the driver.
- Swap edge (PEND=1 and (phase==7 or OE=0)):
  - front <= back (pre-edge value); PEND <= 0.
  - With phase==7, the driver latches old row 7 on that edge and new row 0 on the next edge.
- Write to BACK[r] on a swap edge: front receives the old byte; back takes DIN.
  - If CLRBACK is also set, the written DIN wins over the clear for that row.
- SWAP write on the cycle PEND clears: the new request wins, so PEND stays 1 and the next swap happens on the next boundary.
- SWAP write while PEND=1: no additional effect.
- Writing CTRL with bit0=0 while PEND=1: OE falls on the next edge; the swap executes on the following edge because phase is then 0 with OE=0.
- WE and RE in the same cycle to the same address: DOUT returns the pre-write value.
- Read latency: DOUT is valid one cycle after RE=1 and holds its value while RE=0.
- DATA and OE are registered outputs with no combinational path from the bus.

Optional Feature:
FB_READBACK_EN
- Defined: the read path operates as described above.
- Undefined: RE is ignored, DOUT is tied to 8'h00, and the read mux logic is removed. Writes, swap and PEND behave identically in both builds.

Test Plan:
1. Reset with INIT_PATTERN=64'h0123456789ABCDEF and OE_RESET=0 -> DATA=64'h0123456789ABCDEF, OE=0, PEND=0, DOUT=0, all while RST is still high.
2. OE=0; write BACK[0..7]=8'h01,02,04,...,80; write CTRL=8'h02 -> PEND=1 for exactly one cycle; next edge DATA=64'h8040201008040201, PEND=0.
3. CTRL=8'h01; wait until phase=3; write BACK[7]=8'hFF and CTRL=8'h03 -> DATA unchanged until the edge where phase==7, DATA[63:56]=8'hFF on the following cycle, STATUS read shows phase advancing 3->4...
4. PEND=1 at phase 7 with a simultaneous write BACK[2]=8'hAA -> DATA[23:16] = old value; a subsequent read of BACK[2] returns 8'hAA.
5. CTRL=8'h07 with back=all 8'h55 -> at the swap edge DATA=64'h5555555555555555 and BACK[0..7] read 8'h00.
6. RST asserted mid-frame with PEND=1 at phase 5 -> immediately PEND=0, phase=0, DATA=INIT_PATTERN. With FB_READBACK_EN undefined, the RE of BACK[0] -> DOUT=8'h00.
